mem_stage_lsu: RTL and testbench

// MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers. Takes the
// EX/MEM address/data/control and runs one request/grant/response transaction on the data

---
 rtl/mem_stage_lsu.sv | 211 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// MEM-stage load/store unit. Runs one request/grant/response transaction on the
// data memory port for each load or store in EX/MEM. It holds the pipeline until
// the access completes and returns the raw load word to MEM/WB. Sign or zero
// extension of the load word happens later, in WB.
//
// Ports
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_mem_read/write     EX/MEM load/store strobes (never both high)
//   i_funct3             [1:0] access size: 00 byte, 01 half, 1x word; [2] unused
//   i_addr, i_st_data    byte address and LSB-aligned store data
//   i_stall_IF           global hold; keeps a completed access parked in HOLD
//   o_dm_*               registered data-memory request channel
//   i_dm_gnt             request accepted
//   i_dm_rvalid/rdata    read response
//   i_dm_bvalid          write response
//   o_ld_data            captured load word, held until the stage advances
//   o_stall_mem          pipeline hold while an access is in flight
//   o_misalign_err       one-cycle pulse: a misaligned access was dropped
//   o_bus_err            one-cycle pulse: the response timed out
module mem_stage_lsu #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_stall_IF,
  output logic        o_dm_req,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [3:0]  o_dm_wstrb,
  output logic [31:0] o_dm_wdata,
  input  logic        i_dm_gnt,
  input  logic        i_dm_rvalid,
  input  logic [31:0] i_dm_rdata,
  input  logic        i_dm_bvalid,
  output logic [31:0] o_ld_data,
  output logic        o_stall_mem,
  output logic        o_misalign_err,
  output logic        o_bus_err
);

  // The counter only has to reach TIMEOUT_CYC-1.
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_WAIT_B,
    S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_dm_req;
  logic          r_dm_we;
  logic [31:0]   r_dm_addr;
  logic [3:0]    r_dm_wstrb;
  logic [31:0]   r_dm_wdata;
  logic [31:0]   r_ld_data;
  logic          r_misalign_err;
  logic          r_bus_err;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_size;
  logic          w_access;
  logic          w_mis;
  logic          w_start;
  logic          w_cnt_last;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata;
  logic          w_unused;

  // Bit 2 of funct3 only selects the extension in WB.
  assign w_unused   = i_funct3[2];
  assign w_size     = i_funct3[1:0];
  assign w_access   = i_mem_read | i_mem_write;
  // Size 11 is handled as a word access.
  assign w_mis      = ((w_size == 2'b01) && i_addr[0]) ||
                      (w_size[1] && (i_addr[1:0] != 2'b00));
  assign w_start    = (r_state == S_IDLE) && w_access && !w_mis;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Byte lanes and lane-replicated store data; reads always enable all lanes.
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = i_st_data;
    case (w_size)
      2'b00: begin
        w_wdata = {4{i_st_data[7:0]}};
        if (i_mem_write) w_wstrb = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{i_st_data[15:0]}};
        if (i_mem_write) w_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = i_st_data;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and pipeline stall. A response arriving in the last timeout cycle
  // still wins over the timeout. HOLD is not a stall: the stage may advance.
  always_comb begin
    w_next      = r_state;
    o_stall_mem = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall_mem = w_start;
        if (w_start) w_next = S_REQ;
      end
      S_REQ: begin
        o_stall_mem = 1'b1;
        if (i_dm_gnt) w_next = r_dm_we ? S_WAIT_B : S_WAIT_R;
      end
      S_WAIT_R: begin
        o_stall_mem = 1'b1;
        if (i_dm_rvalid || w_cnt_last) w_next = S_HOLD;
      end
      S_WAIT_B: begin
        o_stall_mem = 1'b1;
        if (i_dm_bvalid || w_cnt_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (!i_stall_IF) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered bus fields, load capture, timeout counter and error pulses.
  // Request fields are captured once in IDLE and stay frozen until the next access.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dm_req       <= 1'b0;
      r_dm_we        <= 1'b0;
      r_dm_addr      <= 32'h0;
      r_dm_wstrb     <= 4'h0;
      r_dm_wdata     <= 32'h0;
      r_ld_data      <= 32'h0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_misalign_err <= (r_state == S_IDLE) && w_access && w_mis;
      r_bus_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_dm_req   <= 1'b1;
            r_dm_we    <= i_mem_write;
            r_dm_addr  <= {i_addr[31:2], 2'b00};
            r_dm_wstrb <= w_wstrb;
            r_dm_wdata <= w_wdata;
          end
        end
        S_REQ: begin
          if (i_dm_gnt) begin
            r_dm_req <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_WAIT_R: begin
          if (i_dm_rvalid) begin
            r_ld_data <= i_dm_rdata;
          end else if (w_cnt_last) begin
            r_ld_data <= 32'h0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_B: begin
          if (i_dm_bvalid) begin
            r_cnt <= r_cnt;
          end else if (w_cnt_last) begin
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign o_dm_req       = r_dm_req;
  assign o_dm_we        = r_dm_we;
  assign o_dm_addr      = r_dm_addr;
  assign o_dm_wstrb     = r_dm_wstrb;
  assign o_dm_wdata     = r_dm_wdata;
  assign o_ld_data      = r_ld_data;
  assign o_misalign_err = r_misalign_err;
  assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
// Directed bench for the MEM-stage load/store unit. Inputs change 1 ns after the
// rising edge and outputs are sampled 1 ns later, so every cycle index c below is
// one clock period. The unit is built with an 8-cycle response timeout.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read, mem_write, stall_IF;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic        dm_gnt, dm_rvalid, dm_bvalid;
  logic [31:0] dm_rdata;
  logic        dm_req, dm_we, stall_mem, misalign_err, bus_err;
  logic [31:0] dm_addr, dm_wdata, ld_data;
  logic [3:0]  dm_wstrb;

  int nChecks = 0;
  int nPass   = 0;

  mem_stage_lsu #(.TIMEOUT_CYC(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
    .i_addr(addr), .i_st_data(st_data), .i_stall_IF(stall_IF),
    .o_dm_req(dm_req), .o_dm_we(dm_we), .o_dm_addr(dm_addr),
    .o_dm_wstrb(dm_wstrb), .o_dm_wdata(dm_wdata),
    .i_dm_gnt(dm_gnt), .i_dm_rvalid(dm_rvalid), .i_dm_rdata(dm_rdata),
    .i_dm_bvalid(dm_bvalid),
    .o_ld_data(ld_data), .o_stall_mem(stall_mem),
    .o_misalign_err(misalign_err), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input logic mr, input logic mw, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic sif, input logic gnt, input logic rv,
                               input logic [31:0] rd, input logic bv);
    mem_read = mr; mem_write = mw; funct3 = f3; addr = a; st_data = sd;
    stall_IF = sif; dm_gnt = gnt; dm_rvalid = rv; dm_rdata = rd; dm_bvalid = bv;
  endtask

  task automatic nextCycle;
    @(posedge clk); #1;
  endtask

  // Reset values, plus stray responses right after reset release being ignored.
  task automatic test_reset;
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    nextCycle(); nextCycle(); #1;
    nChecks++; if ({dm_req, dm_we, stall_mem, misalign_err, bus_err} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000", {dm_req, dm_we, stall_mem, misalign_err, bus_err}); else nPass++;
    nChecks++; if (dm_addr !== 32'h0) $display("[TB] FAIL reset_addr: got %h expected 00000000", dm_addr); else nPass++;
    nChecks++; if ({dm_wstrb, dm_wdata} !== 36'h0) $display("[TB] FAIL reset_wstrb_wdata: got %h expected 000000000", {dm_wstrb, dm_wdata}); else nPass++;
    nChecks++; if (ld_data !== 32'h0) $display("[TB] FAIL reset_ld_data: got %h expected 00000000", ld_data); else nPass++;
    rst = 1'b0;
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 0, 1, 1, 32'hFFFF_FFFF, 1);
    nextCycle(); nextCycle(); #1;
    nChecks++; if (ld_data !== 32'h0) $display("[TB] FAIL stray_rvalid_ld: got %h expected 00000000", ld_data); else nPass++;
    nChecks++; if ({dm_req, stall_mem} !== 2'b00) $display("[TB] FAIL stray_rvalid_req: got %b expected 00", {dm_req, stall_mem}); else nPass++;
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0);
    nextCycle();
  endtask

  // Word load: gnt at c1, rvalid at c3, HOLD at c4, stage advances after c4.
  task automatic test_load_word;
    int stallCnt = 0;
    int reqCnt = 0;
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(c <= 4, 0, 3'b010, 32'h100, 32'h0, 0, c == 1, c == 3,
                    (c == 3) ? 32'hDEAD_BEEF : 32'h0, 0);
      #1;
      if (stall_mem) stallCnt++;
      if (dm_req) reqCnt++;
      if (c == 1) begin
        nChecks++; if (dm_addr !== 32'h100) $display("[TB] FAIL lw_addr: got %h expected 00000100", dm_addr); else nPass++;
        nChecks++; if ({dm_we, dm_wstrb} !== 5'b0_1111) $display("[TB] FAIL lw_we_wstrb: got %b expected 01111", {dm_we, dm_wstrb}); else nPass++;
      end
      if (c == 4) begin
        nChecks++; if (ld_data !== 32'hDEAD_BEEF) $display("[TB] FAIL lw_ld_data: got %h expected deadbeef", ld_data); else nPass++;
      end
      nextCycle();
    end
    nChecks++; if (stallCnt !== 4) $display("[TB] FAIL lw_stall_cycles: got %0d expected 4", stallCnt); else nPass++;
    nChecks++; if (reqCnt !== 1) $display("[TB] FAIL lw_req_cycles: got %0d expected 1", reqCnt); else nPass++;
    nChecks++; if (ld_data !== 32'hDEAD_BEEF) $display("[TB] FAIL lw_ld_held: got %h expected deadbeef", ld_data); else nPass++;
  endtask

  // Byte store to 0x203: gnt c1, bvalid c2, HOLD c3. ld_data must keep the last load.
  task automatic test_store_byte;
    int stallCnt = 0;
    for (int c = 0; c <= 5; c++) begin
      applyStimulus(0, c <= 3, 3'b000, 32'h203, 32'h0000_00A5, 0, c == 1, 0, 32'h0, c == 2);
      #1;
      if (stall_mem) stallCnt++;
      if (c == 1) begin
        nChecks++; if ({dm_req, dm_we} !== 2'b11) $display("[TB] FAIL sb_req_we: got %b expected 11", {dm_req, dm_we}); else nPass++;
        nChecks++; if (dm_wstrb !== 4'b1000) $display("[TB] FAIL sb_wstrb: got %b expected 1000", dm_wstrb); else nPass++;
        nChecks++; if (dm_wdata !== 32'hA5A5_A5A5) $display("[TB] FAIL sb_wdata: got %h expected a5a5a5a5", dm_wdata); else nPass++;
        nChecks++; if (dm_addr !== 32'h200) $display("[TB] FAIL sb_addr: got %h expected 00000200", dm_addr); else nPass++;
      end
      if (c == 3) begin
        nChecks++; if (ld_data !== 32'hDEAD_BEEF) $display("[TB] FAIL sb_ld_unchanged: got %h expected deadbeef", ld_data); else nPass++;
      end
      nextCycle();
    end
    nChecks++; if (stallCnt !== 3) $display("[TB] FAIL sb_stall_cycles: got %0d expected 3", stallCnt); else nPass++;
  endtask

  // Lane selection and replication for other store shapes; funct3 11 acts as word.
  task automatic test_store_lanes;
    logic [2:0]  f3Tab   [3] = '{3'b001, 3'b011, 3'b000};
    logic [31:0] addrTab [3] = '{32'h402, 32'h40C, 32'h001};
    logic [31:0] sdTab   [3] = '{32'h1234_BEEF, 32'h1122_3344, 32'hFFFF_FF3C};
    logic [3:0]  strbExp [3] = '{4'b1100, 4'b1111, 4'b0010};
    logic [31:0] dataExp [3] = '{32'hBEEF_BEEF, 32'h1122_3344, 32'h3C3C_3C3C};
    logic [31:0] addrExp [3] = '{32'h400, 32'h40C, 32'h000};
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c <= 4; c++) begin
        applyStimulus(0, c <= 3, f3Tab[t], addrTab[t], sdTab[t], 0, c == 1, 0, 32'h0, c == 2);
        #1;
        if (c == 1) begin
          nChecks++; if (dm_wstrb !== strbExp[t]) $display("[TB] FAIL lanes_wstrb[%0d]: got %b expected %b", t, dm_wstrb, strbExp[t]); else nPass++;
          nChecks++; if (dm_wdata !== dataExp[t]) $display("[TB] FAIL lanes_wdata[%0d]: got %h expected %h", t, dm_wdata, dataExp[t]); else nPass++;
          nChecks++; if (dm_addr !== addrExp[t]) $display("[TB] FAIL lanes_addr[%0d]: got %h expected %h", t, dm_addr, addrExp[t]); else nPass++;
        end
        nextCycle();
      end
    end
  endtask

  // Misaligned half read and word write are dropped with a single error pulse.
  task automatic test_misaligned;
    logic [2:0]  f3Tab   [2] = '{3'b001, 3'b010};
    logic [31:0] addrTab [2] = '{32'h101, 32'h206};
    logic        wrTab   [2] = '{1'b0, 1'b1};
    for (int t = 0; t < 2; t++) begin
      int reqCnt = 0;
      int stallCnt = 0;
      int errCnt = 0;
      for (int c = 0; c <= 3; c++) begin
        applyStimulus((c == 0) && !wrTab[t], (c == 0) && wrTab[t], f3Tab[t], addrTab[t],
                      32'h1357_9BDF, 0, 0, 0, 32'h0, 0);
        #1;
        if (dm_req) reqCnt++;
        if (stall_mem) stallCnt++;
        if (misalign_err) errCnt++;
        if (c == 1) begin
          nChecks++; if (misalign_err !== 1'b1) $display("[TB] FAIL mis_pulse_c1[%0d]: got %b expected 1", t, misalign_err); else nPass++;
        end
        nextCycle();
      end
      nChecks++; if (reqCnt !== 0) $display("[TB] FAIL mis_no_req[%0d]: got %0d expected 0", t, reqCnt); else nPass++;
      nChecks++; if (stallCnt !== 0) $display("[TB] FAIL mis_no_stall[%0d]: got %0d expected 0", t, stallCnt); else nPass++;
      nChecks++; if (errCnt !== 1) $display("[TB] FAIL mis_pulse_len[%0d]: got %0d expected 1", t, errCnt); else nPass++;
    end
  endtask

  // Grant withheld c1..c5, granted c6 together with a stray rvalid that must be
  // ignored, real rvalid c8, HOLD c9..c11 under stall_IF, stage advances after c11.
  // stall_IF is also high at c0 to show it does not block the start of an access.
  task automatic test_backpressure;
    int stallCnt = 0;
    int reqCnt = 0;
    int holdCnt = 0;
    for (int c = 0; c <= 14; c++) begin
      applyStimulus(c <= 11, 0, 3'b010, (c == 0) ? 32'h300 : 32'h304,
                    (c == 0) ? 32'h0 : 32'h5555_AAAA,
                    (c == 0) || (c == 9) || (c == 10), c == 6, (c == 6) || (c == 8),
                    (c == 6) ? 32'hBAD0_BAD0 : 32'hCAFE_F00D, 0);
      #1;
      if (stall_mem) stallCnt++;
      if (dm_req) reqCnt++;
      if (mem_read && !stall_mem) holdCnt++;
      if (c == 6) begin
        nChecks++; if ({dm_req, dm_addr} !== {1'b1, 32'h300}) $display("[TB] FAIL bp_req_stable: got %b/%h expected 1/00000300", dm_req, dm_addr); else nPass++;
        nChecks++; if (dm_wdata !== 32'h0) $display("[TB] FAIL bp_wdata_stable: got %h expected 00000000", dm_wdata); else nPass++;
      end
      if (c == 9) begin
        nChecks++; if (ld_data !== 32'hCAFE_F00D) $display("[TB] FAIL bp_ld_data: got %h expected cafef00d", ld_data); else nPass++;
      end
      nextCycle();
    end
    nChecks++; if (reqCnt !== 6) $display("[TB] FAIL bp_req_cycles: got %0d expected 6", reqCnt); else nPass++;
    nChecks++; if (stallCnt !== 9) $display("[TB] FAIL bp_stall_cycles: got %0d expected 9", stallCnt); else nPass++;
    nChecks++; if (holdCnt !== 3) $display("[TB] FAIL bp_hold_cycles: got %0d expected 3", holdCnt); else nPass++;
    nChecks++; if (ld_data !== 32'hCAFE_F00D) $display("[TB] FAIL bp_ld_held: got %h expected cafef00d", ld_data); else nPass++;
  endtask

  // No response: WAIT_R c2..c9, HOLD c10 with bus_err and ld_data cleared.
  task automatic test_timeout;
    int stallCnt = 0;
    int errCnt = 0;
    for (int c = 0; c <= 12; c++) begin
      applyStimulus(c <= 10, 0, 3'b010, 32'h400, 32'h0, 0, c == 1, 0, 32'h0, 0);
      #1;
      if (stall_mem) stallCnt++;
      if (bus_err) errCnt++;
      if (c == 9) begin
        nChecks++; if (ld_data !== 32'hCAFE_F00D) $display("[TB] FAIL to_ld_before: got %h expected cafef00d", ld_data); else nPass++;
      end
      if (c == 10) begin
        nChecks++; if ({bus_err, stall_mem} !== 2'b10) $display("[TB] FAIL to_pulse_hold: got %b expected 10", {bus_err, stall_mem}); else nPass++;
        nChecks++; if (ld_data !== 32'h0) $display("[TB] FAIL to_ld_zero: got %h expected 00000000", ld_data); else nPass++;
      end
      nextCycle();
    end
    nChecks++; if (stallCnt !== 10) $display("[TB] FAIL to_stall_cycles: got %0d expected 10", stallCnt); else nPass++;
    nChecks++; if (errCnt !== 1) $display("[TB] FAIL to_pulse_len: got %0d expected 1", errCnt); else nPass++;
  endtask

  // Reset mid-cycle in REQ (dm_req must drop without a clock edge), then reset in
  // WAIT_R followed by a late rvalid that must not be captured.
  task automatic test_async_reset;
    for (int c = 0; c <= 1; c++) begin
      applyStimulus(1, 0, 3'b010, 32'h500, 32'h0, 0, 0, 0, 32'h0, 0);
      #1;
      if (c == 1) begin
        nChecks++; if (dm_req !== 1'b1) $display("[TB] FAIL ar_req_before: got %b expected 1", dm_req); else nPass++;
        mem_read = 1'b0;
        rst = 1'b1;
        #1;
        nChecks++; if ({dm_req, stall_mem} !== 2'b00) $display("[TB] FAIL ar_req_async_drop: got %b expected 00", {dm_req, stall_mem}); else nPass++;
        rst = 1'b0;
      end
      nextCycle();
    end
    for (int c = 0; c <= 2; c++) begin
      applyStimulus(1, 0, 3'b010, 32'h500, 32'h0, 0, c == 1, 0, 32'h0, 0);
      #1;
      if (c == 2) begin
        nChecks++; if (stall_mem !== 1'b1) $display("[TB] FAIL ar_in_wait: got %b expected 1", stall_mem); else nPass++;
        mem_read = 1'b0;
        rst = 1'b1;
        #1;
        nChecks++; if ({stall_mem, dm_addr} !== {1'b0, 32'h0}) $display("[TB] FAIL ar_wait_clear: got %b/%h expected 0/00000000", stall_mem, dm_addr); else nPass++;
        rst = 1'b0;
      end
      nextCycle();
    end
    applyStimulus(0, 0, 3'b010, 32'h0, 32'h0, 0, 0, 1, 32'h1234_5678, 0);
    nextCycle(); nextCycle(); #1;
    nChecks++; if (ld_data !== 32'h0) $display("[TB] FAIL ar_ld_zero: got %h expected 00000000", ld_data); else nPass++;
    nChecks++; if ({dm_req, stall_mem} !== 2'b00) $display("[TB] FAIL ar_idle: got %b expected 00", {dm_req, stall_mem}); else nPass++;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_lanes();
    test_misaligned();
    test_backpressure();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
